// File: rtl/cpu_div_cell.sv
// Radix-2 restoring 32-bit divider for the execute stage: fixed WIDTH+2 cycle
// latency, signed (truncating) or unsigned, with pipeline kill.
//   state  | meaning
//   S_IDLE | waiting for start; operands captured and made positive on accept
//   S_ITER | one quotient bit per cycle, WIDTH cycles
//   S_FIX  | sign / divide-by-zero correction, outputs written, done pulsed
module cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             E_start,
  input  logic             E_signed,
  input  logic             E_kill,
  output logic [WIDTH-1:0] D_quotient,
  output logic [WIDTH-1:0] D_remainder,
  output logic             D_busy,
  output logic             D_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_raw_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             neg_q_q, neg_r_q, busy_q, done_q;

  logic             src1_neg, src2_neg;
  logic [WIDTH-1:0] src1_mag, src2_mag;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] quo_sh, rem_d, quo_d, fix_q, fix_r;

  always_comb begin
    src1_neg = E_signed & E_src1[WIDTH-1];
    src2_neg = E_signed & E_src2[WIDTH-1];
    src1_mag = src1_neg ? -E_src1 : E_src1;
    src2_mag = src2_neg ? -E_src2 : E_src2;

    // Partial remainder never exceeds the divisor, so WIDTH bits hold it;
    // the extra bit only lives in the shifted value and the trial borrow.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    quo_sh = {quo_q[WIDTH-2:0], 1'b0};
    trial  = rem_sh - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      quo_d = quo_sh;
    end

    if (dvs_q == '0) begin
      fix_q = '1;
      fix_r = dvd_raw_q;
    end else begin
      fix_q = neg_q_q ? -quo_q : quo_q;
      fix_r = neg_r_q ? -rem_q : rem_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dvd_raw_q   <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (E_start && !E_kill) begin
            dvd_raw_q <= E_src1;
            quo_q     <= src1_mag;
            dvs_q     <= src2_mag;
            rem_q     <= '0;
            neg_q_q   <= src1_neg ^ src2_neg;
            neg_r_q   <= src1_neg;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_ITER;
          end
        end
        S_ITER: begin
          if (E_kill) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (cnt_q == LAST_CNT) begin
              cnt_q   <= '0;
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        S_FIX: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!E_kill) begin
            quotient_q  <= fix_q;
            remainder_q <= fix_r;
            done_q      <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign D_quotient  = quotient_q;
  assign D_remainder = remainder_q;
  assign D_busy      = busy_q;
  assign D_done      = done_q;

endmodule
